// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and the IF/ID register bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;
    localparam int JT_LSB     = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational field extraction and instruction-class flags
// for the word held in the IF/ID register.
module instr_fields
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [31:0] imm_sext,
    output logic [31:0] br_off,
    output logic [25:0] jtarget,
    output logic        is_rtype,
    output logic        is_jump,
    output logic        is_branch
);

    assign opcode   = instr[OPCODE_LSB +: 6];
    assign rs       = instr[RS_LSB +: 5];
    assign rt       = instr[RT_LSB +: 5];
    assign rd       = instr[RD_LSB +: 5];
    assign shamt    = instr[SHAMT_LSB +: 5];
    assign funct    = instr[FUNCT_LSB +: 6];
    assign imm      = instr[IMM_LSB +: 16];
    assign jtarget  = instr[JT_LSB +: 26];
    assign imm_sext = sext16(imm);
    assign br_off   = {imm_sext[29:0], 2'b00};

    // A bubble decodes as opcode 0, so flags must be gated by valid.
    assign is_rtype  = valid && (opcode == OP_RTYPE);
    assign is_jump   = valid && (opcode == OP_J || opcode == OP_JAL);
    assign is_branch = valid && (opcode == OP_BEQ || opcode == OP_BNE);

endmodule

// File: rtl/if_id_split.sv
// IF/ID pipeline register with stall/flush and a decoded view
// of the held instruction word.
module if_id_split
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc_plus4,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [31:0] imm_sext,
    output logic [31:0] br_off,
    output logic [25:0] jtarget,
    output logic [3:0]  pc_nibble,
    output logic [31:0] pc_plus4,
    output logic        is_rtype,
    output logic        is_jump,
    output logic        is_branch
);

    if_id_t q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            q.instr    <= NOP_INSTR;
            q.pc_plus4 <= 32'h0;
            q.valid    <= 1'b0;
        end else if (!stall) begin
            q.instr    <= in_valid ? in_instr : NOP_INSTR;
            q.pc_plus4 <= in_pc_plus4;
            q.valid    <= in_valid;
        end
    end

    assign out_valid = q.valid;
    assign pc_plus4  = q.pc_plus4;
    assign pc_nibble = q.pc_plus4[31:28];

    instr_fields u_fields (
        .instr     (q.instr),
        .valid     (q.valid),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm       (imm),
        .imm_sext  (imm_sext),
        .br_off    (br_off),
        .jtarget   (jtarget),
        .is_rtype  (is_rtype),
        .is_jump   (is_jump),
        .is_branch (is_branch)
    );

endmodule

// File: doc/if_id_split.md
IF_ID_SPLIT -- requirements
Module: if_id_split

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0000, the instruction word held in the register after reset or flush.
REQ-002 SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  a fetched instruction is present.
REQ-005 SHALL have port in_instr  input  32  the fetched instruction word.
REQ-006 SHALL have port in_pc_plus4  input  32  the fetch PC plus 4.
REQ-007 SHALL have port stall  input  1  hold the register contents (hazard unit).
REQ-008 SHALL have port flush  input  1  replace the register contents with a bubble (taken branch or jump).
REQ-009 SHALL have port out_valid  output  1  the decode-stage instruction is live.
REQ-010 SHALL have ports opcode, rs, rt, rd, shamt and funct, all outputs, widths 6/5/5/5/5/6, holding instruction bits [31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0].
REQ-011 SHALL have port imm  output  16  instruction bits [15:0].
REQ-012 SHALL have port imm_sext  output  32  imm sign-extended to 32 bits.
REQ-013 SHALL have port br_off  output  32  imm_sext shifted left by 2.
REQ-014 SHALL have port jtarget  output  26  instruction bits [25:0].
REQ-015 SHALL have port pc_nibble  output  4  registered pc_plus4[31:28].
REQ-016 SHALL have port pc_plus4  output  32  registered in_pc_plus4.
REQ-017 SHALL have ports is_rtype, is_jump and is_branch, all outputs, width 1: opcode==0; opcode 2 or 3; opcode 4 or 5.

Function
REQ-018 SHALL register the instruction word, pc_plus4 and valid on the rising edge of clk, giving 1-cycle latency from the inputs to all outputs.
REQ-019 SHALL derive every field output combinationally from the registered instruction word only, so that no input-to-output combinational path exists.
REQ-020 SHALL load in_instr, in_pc_plus4 and in_valid when stall=0 and flush=0.
REQ-021 SHALL hold all registered state unchanged when stall=1 and flush=0, regardless of in_valid or in_instr.
REQ-022 SHALL load NOP_INSTR, set out_valid=0 and clear pc_plus4 to 0 when flush=1, whether or not stall is asserted, because flush has priority.
REQ-023 SHALL load NOP_INSTR with out_valid=0 when in_valid=0 and the register is not stalled, so the fields never show a stale instruction.
REQ-024 SHALL compute imm_sext as 16 copies of imm[15] followed by imm, and br_off as imm_sext[29:0] followed by 2'b00, discarding the upper two bits.
REQ-025 SHALL force is_rtype, is_jump and is_branch to 0 whenever out_valid=0.
REQ-026 SHALL have no internal state beyond the instruction, pc_plus4 and valid registers.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, load NOP_INSTR, clear pc_plus4 and clear out_valid, with priority over stall and flush.
REQ-028 SHALL, after reset, drive out_valid=0, every field output as decoded from NOP_INSTR (all zeros by default), imm_sext=0, br_off=0 and all type flags 0.
REQ-029 SHALL complete a reset asserted mid-stall in one edge and SHALL accept new input on the first edge with rst_n=1.

Structure
REQ-030 SHALL take the opcode constants (OP_RTYPE=0, OP_J=2, OP_JAL=3, OP_BEQ=4, OP_BNE=5) and the field bit positions from the shared mips_pkg package.
REQ-031 SHALL place field extraction and the type flags in one combinational sub-module, instr_fields, instantiated on the registered word.

Verification
REQ-032 SHALL cover: in_instr=32'h0022_1820 with in_valid=1 -> next cycle opcode=0, rs=1, rt=2, rd=3, shamt=0, funct=6'h20, is_rtype=1, out_valid=1.
REQ-033 SHALL cover: in_instr=32'h0810_0004 with in_pc_plus4=32'hA040_0008 -> jtarget=26'h010_0004, pc_nibble=4'hA, is_jump=1.
REQ-034 SHALL cover: in_instr=32'h1022_FFFF (beq) -> imm_sext=32'hFFFF_FFFF, br_off=32'hFFFF_FFFC, is_branch=1.
REQ-035 SHALL cover: load 32'h0022_1820, then stall=1 for 3 cycles while in_instr changes -> outputs unchanged for all 3 cycles, new word loads on the first unstalled edge.
REQ-036 SHALL cover: stall=1 and flush=1 in the same cycle -> out_valid=0, all fields 0, all flags 0 on the next cycle.
REQ-037 SHALL cover: rst_n=0 for one edge during a stall holding a valid word -> out_valid=0 and pc_plus4=0 next cycle, with normal loading resuming afterwards.
